// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Upstream stage of the Pac-Man direction controller. Deframes raw PS/2
// keyboard traffic (start, 8 data bits LSB first, odd parity, stop), resolves
// the E0 (extended) and F0 (break) prefixes and presents each key event as an
// 8-bit scan code with a one-cycle ps2_ready strobe.
//
// Optional feature macro: PS2_BREAK_EN
//   undefined - break events are swallowed silently, no ps2_release port
//   defined   - break events are reported too, flagged by ps2_release=1
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_code,
    output logic       ps2_ready,
    output logic       ps2_ext,
    output logic       frame_err
`ifdef PS2_BREAK_EN
    ,
    output logic       ps2_release
`endif
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Input synchronizers
    logic          clk_meta;
    logic          clk_sync;
    logic          data_meta;
    logic          data_sync;

    // Glitch filter on the PS/2 clock
    logic [FW-1:0] filt_cnt;
    logic          clk_filt;
    logic          clk_filt_d;
    logic          fall;

    // Frame receiver
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          byte_valid;
    logic [7:0]    byte_data;

    // Prefix tracking
    logic          ext_flag;
    logic          brk_flag;

    // Bring both asynchronous keyboard lines into the clk domain; idle level is high
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Filtered clock follows the synced clock only after FILTER_LEN differing samples in a row
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_sync == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign fall    = clk_filt_d & ~clk_filt;
    assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

    // Frame receiver: advances on filtered falling edges, aborts on an inter-edge timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout) begin
                state     <= IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else if (fall) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= data_sync;
                        state      <= STOP;
                    end
                    STOP: begin
                        if (data_sync && (^{shift_reg, parity_bit})) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // Prefix layer: remember E0/F0, then turn the final byte into a key event
    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            ps2_code    <= 8'h00;
            ps2_ext     <= 1'b0;
            ps2_ready   <= 1'b0;
`ifdef PS2_BREAK_EN
            ps2_release <= 1'b0;
`endif
        end else begin
            ps2_ready <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_valid) begin
                if (byte_data == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (byte_data == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
`ifdef PS2_BREAK_EN
                    ps2_code    <= byte_data;
                    ps2_ext     <= ext_flag;
                    ps2_ready   <= 1'b1;
                    ps2_release <= brk_flag;
`else
                    if (!brk_flag) begin
                        ps2_code  <= byte_data;
                        ps2_ext   <= ext_flag;
                        ps2_ready <= 1'b1;
                    end
`endif
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Drives byte-level PS/2 frames into ps2_key_decoder and compares every
// output cycle against an event-queue model of the keyboard protocol.
// Honours PS2_BREAK_EN the same way the design does.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 400;
    localparam int HALF           = 30;
    localparam int GAP            = 40;
    localparam int LATENCY        = FILTER_LEN + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ps2_code;
    logic       ps2_ready;
    logic       ps2_ext;
    logic       frame_err;
`ifdef PS2_BREAK_EN
    logic       ps2_release;
`endif

    ps2_key_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_code   (ps2_code),
        .ps2_ready  (ps2_ready),
        .ps2_ext    (ps2_ext),
        .frame_err  (frame_err)
`ifdef PS2_BREAK_EN
        ,
        .ps2_release(ps2_release)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ev_t;

    // Model state
    ev_t  exp_q[$];
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    int   exp_ready = 0;
    int   exp_err = 0;

    // Observation state
    int   checks = 0;
    int   failures = 0;
    int   ready_seen = 0;
    int   err_seen = 0;
    int   cyc = 0;
    int   stop_fall_cyc = 0;
    logic prev_ready = 1'b0;
    ev_t  held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model of one correctly framed byte arriving at the prefix layer
    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            e.code = b;
            e.ext  = m_ext;
            e.rel  = m_brk;
`ifdef PS2_BREAK_EN
            exp_q.push_back(e);
            exp_ready++;
`else
            if (!m_brk) begin
                exp_q.push_back(e);
                exp_ready++;
            end
`endif
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_error();
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic ps2_bit(input logic d, input bit is_stop);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (is_stop) stop_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = (~^b) ^ bad_par;
        f[10]   = ~bad_stop;
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == 10);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        model_byte(b);
        apply_stimulus(b, 1'b0, 1'b0, 11);
    endtask

    task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        model_error();
        apply_stimulus(b, bad_par, bad_stop, 11);
    endtask

    // Compare process: every out-of-reset cycle, outputs must match the model
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            held = '0;
        end else begin
            if (frame_err) err_seen++;
            if (ps2_ready) begin
                ready_seen++;
                check_output("ready_width", {31'd0, prev_ready}, 32'd0);
                check_output("ready_latency", cyc - stop_fall_cyc, LATENCY);
                if (exp_q.size() == 0) begin
                    check_output("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("event_code", {24'd0, ps2_code}, {24'd0, e.code});
                    check_output("event_ext", {31'd0, ps2_ext}, {31'd0, e.ext});
`ifdef PS2_BREAK_EN
                    check_output("event_release", {31'd0, ps2_release}, {31'd0, e.rel});
`endif
                    held = e;
                end
            end else begin
                check_output("hold_code", {24'd0, ps2_code}, {24'd0, held.code});
                check_output("hold_ext", {31'd0, ps2_ext}, {31'd0, held.ext});
`ifdef PS2_BREAK_EN
                check_output("hold_release", {31'd0, ps2_release}, {31'd0, held.rel});
`endif
            end
        end
        prev_ready = ps2_ready;
    end

    initial begin
        logic [7:0] b;
        int         r;

        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check_output("reset_code", {24'd0, ps2_code}, 32'h00);
        check_output("reset_ready", {31'd0, ps2_ready}, 32'd0);
        check_output("reset_ext", {31'd0, ps2_ext}, 32'd0);
        check_output("reset_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Plain make code
        send_good(8'h1D);
        check_output("first_code", {24'd0, ps2_code}, 32'h1D);
        check_output("first_ext", {31'd0, ps2_ext}, 32'd0);
        check_output("first_ready_count", ready_seen, 1);

        // Extended make code, E0 itself produces nothing
        send_good(8'hE0);
        check_output("e0_no_ready", ready_seen, 1);
        send_good(8'h6B);
        check_output("ext_code", {24'd0, ps2_code}, 32'h6B);
        check_output("ext_flag", {31'd0, ps2_ext}, 32'd1);
        check_output("ext_ready_count", ready_seen, 2);

        // Extended break
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
`ifdef PS2_BREAK_EN
        check_output("brk_code", {24'd0, ps2_code}, 32'h75);
        check_output("brk_ext", {31'd0, ps2_ext}, 32'd1);
        check_output("brk_release", {31'd0, ps2_release}, 32'd1);
        check_output("brk_ready_count", ready_seen, 3);
`else
        check_output("brk_code_kept", {24'd0, ps2_code}, 32'h6B);
        check_output("brk_ready_count", ready_seen, 2);
`endif

        // Parity error, then recovery
        r = ready_seen;
        send_bad(8'h1D, 1'b1, 1'b0);
        check_output("parity_err_count", err_seen, 1);
        check_output("parity_no_ready", ready_seen, r);
        send_good(8'h1C);
        check_output("after_parity_code", {24'd0, ps2_code}, 32'h1C);
        check_output("after_parity_ext", {31'd0, ps2_ext}, 32'd0);

        // Timeout after 4 data bits; the pending E0 must be forgotten
        send_good(8'hE0);
        model_error();
        apply_stimulus(8'h5A, 1'b0, 1'b0, 5);
        repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
        check_output("timeout_err_count", err_seen, 2);
        send_good(8'h72);
        check_output("after_timeout_code", {24'd0, ps2_code}, 32'h72);
        check_output("after_timeout_ext", {31'd0, ps2_ext}, 32'd0);

        // Typematic repeats and repeated prefixes
        r = ready_seen;
        send_good(8'h1D);
        send_good(8'h1D);
        send_good(8'h1D);
        check_output("typematic_count", ready_seen - r, 3);
        send_good(8'hE0);
        send_good(8'hE0);
        send_good(8'h74);
        check_output("double_e0_ext", {31'd0, ps2_ext}, 32'd1);

        // Short glitch on an idle line
        r = ready_seen;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        check_output("glitch_no_err", err_seen, 2);
        check_output("glitch_no_ready", ready_seen, r);

        // Start bit of 1 is rejected
        model_error();
        ps2_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
        check_output("bad_start_err", err_seen, 3);

        // Reset in the middle of a frame
        apply_stimulus(8'h33, 1'b0, 1'b0, 4);
        rst = 1'b0;
        @(negedge clk);
        check_output("midrst_code", {24'd0, ps2_code}, 32'h00);
        check_output("midrst_ready", {31'd0, ps2_ready}, 32'd0);
        check_output("midrst_ext", {31'd0, ps2_ext}, 32'd0);
        check_output("midrst_err", {31'd0, frame_err}, 32'd0);
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        repeat (20) @(negedge clk);
        send_good(8'h74);
        check_output("after_reset_code", {24'd0, ps2_code}, 32'h74);
        check_output("after_reset_ext", {31'd0, ps2_ext}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(0, 255));
            if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
            case (r)
                0, 1:    send_good(8'hE0);
                2:       send_good(8'hF0);
                3:       send_bad(b, 1'b1, 1'b0);
                4:       send_bad(b, 1'b0, 1'b1);
                default: send_good(b);
            endcase
        end

        repeat (50) @(negedge clk);
        check_output("queue_empty", exp_q.size(), 0);
        check_output("total_ready", ready_seen, exp_ready);
        check_output("total_err", err_seen, exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
